keycode_entry: RTL and testbench
================================

// Module: keycode_entry
// PURPOSE
//   Receiving end of the keypad encoder's keycode/keystrobe interface. Edge-detects
//   keystrobe and treats each new key press as a digit or an edit command. Collects
//   up to NDIGITS BCD digits in a shift buffer and drives per-digit seven-segment
//   patterns. On ENTER, hands off the completed number with a one-cycle valid pulse.
//   Sits between key_encoder and the ss7..ss0 display / game logic in top.
// PARAMETERS
//   NDIGITS  8  digits held in buffer and drives on ss (1..8)
//   CW       $clog2(NDIGITS+1)  width of count/value_len (derived, do not override)
// PORTS
//   clk          in   1            system clock (hwclk in top)
//   reset        in   1            synchronous, active-high reset
//   keycode      in   4            encoder keycode; valid while keystrobe=1
//   keystrobe    in   1            high while a key is held (level, same clk domain)
//   digits       out  4*NDIGITS    BCD buffer; [3:0] = most recent digit
//   count        out  CW           number of valid digits, 0..NDIGITS
//   ss           out  8*NDIGITS    7-seg patterns, byte i for digit i, {dp,g,f,e,d,c,b,a}
//   value        out  4*NDIGITS    last entered number (BCD, same layout as digits)
//   value_len    out  CW           digit count of value
//   value_valid  out  1            1-cycle pulse: value/value_len just updated
//   overflow     out  1            1-cycle pulse: digit key pressed with buffer full
// BEHAVIOUR
//   Reset (synchronous, active-high, at clk edge): digits=0, count=0, value=0,
//     value_len=0, value_valid=0, overflow=0, strobe_q=1.
//   strobe_q is reset to 1 so that a key held through reset is not taken as a press.
//   Edge detect: press = keystrobe & ~strobe_q; strobe_q <= keystrobe every cycle.
//   Holding a key produces exactly one press. Press is evaluated in the cycle where
//     keystrobe is first sampled high. All effects are visible 1 cycle later (registered).
//   Key actions on press, by keycode:
//     0-9  DIGIT:  if count<NDIGITS: digits <= {digits[4*NDIGITS-5:0], keycode};
//                  count++.
//                  else: buffer unchanged; overflow=1 for 1 cycle.
//     10   BKSP:   if count>0: digits <= {4'h0, digits[4*NDIGITS-1:4]}; count--.
//                  else no-op.
//     11   CLEAR:  digits=0, count=0 (legal when already empty).
//     12   ENTER:  if count>0: value<=digits, value_len<=count, value_valid=1 (1 cycle);
//                  same edge: digits=0, count=0.
//                  if count==0: no-op, no pulse.
//     13-15        ignored, no state change.
//   value_valid and overflow are 0 in every cycle without a qualifying press.
//   They never assert together.
//   value holds its contents until the next qualifying ENTER or reset.
//   ss (combinational from digits/count):
//     byte i = seg(digits[4i+3:4i]) if i<count, else 8'h00 (blank); dp always 0.
//     seg: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//     BCD >9 cannot occur; decode it as 8'h00.
//   FSM: none beyond strobe_q. Buffer state is fully described by {digits, count}.
//   Reset mid-press with keystrobe held: no press until keystrobe falls and rises again.
//   keycode changing while keystrobe is held: ignored (only the edge cycle is sampled).
// TESTING
//   1 reset with keystrobe=1, then hold 5 cycles -> count=0, no overflow/value_valid;
//     release, then press 7 -> count=1, ss[7:0]=07.
//   2 press 1,2,3 (strobe held 4 cycles each) -> digits[11:0]=12'h123, count=3,
//     ss[23:0]=06_5B_4F (byte2..0), upper bytes 00.
//   3 from test 2, BKSP -> digits[7:0]=8'h12, count=2;
//     BKSP x3 -> count=0, digits=0, no underflow.
//   4 press 9 nine times (NDIGITS=8) -> count=8, digits=32'h99999999;
//     9th press -> overflow 1 cycle, buffer unchanged.
//   5 enter 4,2 then ENTER -> next cycle value[7:0]=8'h42, value_len=2,
//     value_valid=1 exactly 1 cycle; count=0.
//     ENTER on empty buffer -> no pulse.
//   6 press keycode 13/14/15 and CLEAR on empty buffer -> no state change;
//     CLEAR after 3 digits -> count=0, ss all 00.

Source files
------------

// File: rtl/keycode_entry.sv
// ---------------------------------------------------------------------------
// keycode_entry
//   Receiving end of the keypad encoder's keycode/keystrobe interface.
//   A new key press is detected on the rising edge of keystrobe. Each press is
//   handled as either a BCD digit or an edit command. Digits are collected in a
//   shift buffer, and one seven-segment pattern is driven per buffered digit.
//   ENTER hands the completed number off together with a one-cycle valid pulse.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   keycode      encoder keycode; sampled only in the press cycle
//   keystrobe    high while a key is held (level, same clock domain)
//   digits       BCD buffer; [3:0] is the most recent digit
//   count        number of valid digits, 0..NDIGITS
//   ss           7-seg patterns, byte i for digit i, {dp,g,f,e,d,c,b,a}
//   value        last entered number (same layout as digits)
//   value_len    digit count of value
//   value_valid  one-cycle pulse: value/value_len were just updated
//   overflow     one-cycle pulse: digit key pressed while the buffer was full
// ---------------------------------------------------------------------------
module keycode_entry #(
    parameter int NDIGITS = 8,
    parameter int CW      = $clog2(NDIGITS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             keycode,
    input  logic                   keystrobe,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [CW-1:0]          count,
    output logic [8*NDIGITS-1:0]   ss,
    output logic [4*NDIGITS-1:0]   value,
    output logic [CW-1:0]          value_len,
    output logic                   value_valid,
    output logic                   overflow
);

    localparam logic [3:0] KEY_BKSP  = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;
    localparam logic [3:0] KEY_ENTER = 4'd12;

    logic                  strobe_q, strobe_d;
    logic [4*NDIGITS-1:0]  digits_q, digits_d;
    logic [CW-1:0]         count_q, count_d;
    logic [4*NDIGITS-1:0]  value_q, value_d;
    logic [CW-1:0]         value_len_q, value_len_d;
    logic                  value_valid_q, value_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  press;

    // A press exists only in the first cycle keystrobe is seen high.
    assign press = keystrobe & ~strobe_q;

    always_comb begin
        strobe_d      = keystrobe;
        digits_d      = digits_q;
        count_d       = count_q;
        value_d       = value_q;
        value_len_d   = value_len_q;
        value_valid_d = 1'b0;
        overflow_d    = 1'b0;

        if (press) begin
            if (keycode <= 4'd9) begin
                if (count_q < CW'(NDIGITS)) begin
                    // New digit enters at the bottom; the oldest shifts up.
                    digits_d      = digits_q << 4;
                    digits_d[3:0] = keycode;
                    count_d       = count_q + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                case (keycode)
                    KEY_BKSP: begin
                        if (count_q != '0) begin
                            digits_d = digits_q >> 4;
                            count_d  = count_q - CW'(1);
                        end
                    end
                    KEY_CLEAR: begin
                        digits_d = '0;
                        count_d  = '0;
                    end
                    KEY_ENTER: begin
                        if (count_q != '0) begin
                            value_d       = digits_q;
                            value_len_d   = count_q;
                            value_valid_d = 1'b1;
                            digits_d      = '0;
                            count_d       = '0;
                        end
                    end
                    default: begin
                        // Keycodes 13..15 carry no meaning here.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Start "already held" so a key kept down through reset is not a press.
            strobe_q      <= 1'b1;
            digits_q      <= '0;
            count_q       <= '0;
            value_q       <= '0;
            value_len_q   <= '0;
            value_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            strobe_q      <= strobe_d;
            digits_q      <= digits_d;
            count_q       <= count_d;
            value_q       <= value_d;
            value_len_q   <= value_len_d;
            value_valid_q <= value_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign digits      = digits_q;
    assign count       = count_q;
    assign value       = value_q;
    assign value_len   = value_len_q;
    assign value_valid = value_valid_q;
    assign overflow    = overflow_q;

    // Per-digit seven-segment decode; positions at or above count are blank.
    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_seg
            logic [3:0] nib;
            logic [7:0] pattern;

            assign nib = digits_q[4*gi +: 4];

            always_comb begin
                case (nib)
                    4'd0:    pattern = 8'h3F;
                    4'd1:    pattern = 8'h06;
                    4'd2:    pattern = 8'h5B;
                    4'd3:    pattern = 8'h4F;
                    4'd4:    pattern = 8'h66;
                    4'd5:    pattern = 8'h6D;
                    4'd6:    pattern = 8'h7D;
                    4'd7:    pattern = 8'h07;
                    4'd8:    pattern = 8'h7F;
                    4'd9:    pattern = 8'h6F;
                    default: pattern = 8'h00;
                endcase
            end

            assign ss[8*gi +: 8] = (CW'(gi) < count_q) ? pattern : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_keycode_entry.sv
// ---------------------------------------------------------------------------
// tb_keycode_entry
//   Directed and random key sequences are applied to keycode_entry. Every
//   cycle, all outputs are compared with a reference model. The model keeps the
//   digit buffer as a queue of entered digits, with the most recent digit at the
//   back.
// ---------------------------------------------------------------------------
module tb_keycode_entry;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        keycode;
    logic              keystrobe;
    logic [4*N-1:0]    digits;
    logic [CW-1:0]     count;
    logic [8*N-1:0]    ss;
    logic [4*N-1:0]    value;
    logic [CW-1:0]     value_len;
    logic              value_valid;
    logic              overflow;

    keycode_entry #(.NDIGITS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .keycode     (keycode),
        .keystrobe   (keystrobe),
        .digits      (digits),
        .count       (count),
        .ss          (ss),
        .value       (value),
        .value_len   (value_len),
        .value_valid (value_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            q[$];
    logic [4*N-1:0] m_value;
    int            m_vlen;
    bit            m_vv;
    bit            m_ov;
    logic [7:0]    seg_tab [10];

    function automatic logic [4*N-1:0] pack_digits();
        logic [4*N-1:0] v;
        v = '0;
        for (int i = 0; i < q.size(); i++)
            v[4*i +: 4] = 4'(q[q.size()-1-i]);
        return v;
    endfunction

    function automatic logic [8*N-1:0] exp_ss();
        logic [8*N-1:0] v;
        v = '0;
        for (int i = 0; i < q.size(); i++)
            v[8*i +: 8] = seg_tab[q[q.size()-1-i]];
        return v;
    endfunction

    task automatic model_key(input int k);
        m_vv = 0;
        m_ov = 0;
        if (k <= 9) begin
            if (q.size() < N) q.push_back(k);
            else              m_ov = 1;
        end else if (k == 10) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (k == 11) begin
            q.delete();
        end else if (k == 12) begin
            if (q.size() > 0) begin
                m_value = pack_digits();
                m_vlen  = q.size();
                m_vv    = 1;
                q.delete();
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_value = '0;
        m_vlen  = 0;
        m_vv    = 0;
        m_ov    = 0;
    endtask

    task automatic check_all(input string tag);
        logic [4*N-1:0] e_dig;
        logic [8*N-1:0] e_ss;
        e_dig = pack_digits();
        e_ss  = exp_ss();
        total++;
        assert (digits === e_dig) else begin
            bad++;
            $error("FAIL %s digits: got %h want %h", tag, digits, e_dig);
        end
        total++;
        assert (count === CW'(q.size())) else begin
            bad++;
            $error("FAIL %s count: got %0d want %0d", tag, count, q.size());
        end
        total++;
        assert (ss === e_ss) else begin
            bad++;
            $error("FAIL %s ss: got %h want %h", tag, ss, e_ss);
        end
        total++;
        assert (value === m_value) else begin
            bad++;
            $error("FAIL %s value: got %h want %h", tag, value, m_value);
        end
        total++;
        assert (value_len === CW'(m_vlen)) else begin
            bad++;
            $error("FAIL %s value_len: got %0d want %0d", tag, value_len, m_vlen);
        end
        total++;
        assert (value_valid === m_vv) else begin
            bad++;
            $error("FAIL %s value_valid: got %b want %b", tag, value_valid, m_vv);
        end
        total++;
        assert (overflow === m_ov) else begin
            bad++;
            $error("FAIL %s overflow: got %b want %b", tag, overflow, m_ov);
        end
    endtask

    // Idle or held cycle: no press may occur, so both pulses are expected low.
    task automatic quiet_cycle(input string tag);
        @(posedge clk);
        #1;
        m_vv = 0;
        m_ov = 0;
        check_all(tag);
    endtask

    // One key press: strobe held for 'hold' cycles (keycode scrambled after the
    // edge), then released for 'gap' cycles.
    task automatic press(input int k, input int hold, input int gap, input string tag);
        keycode   = 4'(k);
        keystrobe = 1'b1;
        @(posedge clk);
        #1;
        model_key(k);
        check_all(tag);
        $display("press key=%0d count=%0d value_valid=%b overflow=%b",
                 k, count, value_valid, overflow);
        for (int i = 1; i < hold; i++) begin
            keycode = 4'($urandom_range(0, 15));
            quiet_cycle(tag);
        end
        keystrobe = 1'b0;
        for (int i = 0; i < gap; i++) quiet_cycle(tag);
    endtask

    task automatic do_reset(input bit held, input string tag);
        reset     = 1'b1;
        keystrobe = held;
        keycode   = 4'd7;
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        reset = 1'b0;
        $display("reset held=%b", held);
        if (held) for (int i = 0; i < 5; i++) quiet_cycle(tag);
        keystrobe = 1'b0;
        quiet_cycle(tag);
    endtask

    initial begin
        seg_tab[0] = 8'h3F; seg_tab[1] = 8'h06; seg_tab[2] = 8'h5B; seg_tab[3] = 8'h4F;
        seg_tab[4] = 8'h66; seg_tab[5] = 8'h6D; seg_tab[6] = 8'h7D; seg_tab[7] = 8'h07;
        seg_tab[8] = 8'h7F; seg_tab[9] = 8'h6F;
        reset     = 1'b0;
        keystrobe = 1'b0;
        keycode   = 4'd0;
        model_reset();

        // 1: reset while a key is held, then a real press of 7
        do_reset(1'b1, "t1_reset_held");
        press(7, 2, 1, "t1_press7");
        total++;
        assert (ss[7:0] === 8'h07) else begin
            bad++;
            $error("FAIL t1_ss0: got %h want 07", ss[7:0]);
        end

        // 2: digits 1,2,3
        press(11, 1, 1, "t2_clear");
        press(1, 4, 1, "t2_d1");
        press(2, 4, 1, "t2_d2");
        press(3, 4, 1, "t2_d3");
        total++;
        assert (digits[11:0] === 12'h123) else begin
            bad++;
            $error("FAIL t2_digits: got %h want 123", digits[11:0]);
        end

        // 3: backspace down to empty and past it
        press(10, 2, 1, "t3_bksp1");
        total++;
        assert (digits[7:0] === 8'h12) else begin
            bad++;
            $error("FAIL t3_digits: got %h want 12", digits[7:0]);
        end
        for (int i = 0; i < 3; i++) press(10, 2, 1, "t3_bksp_more");

        // 4: fill buffer with 9s, ninth press overflows
        for (int i = 0; i < 9; i++) press(9, 2, 1, "t4_nines");

        // 5: ENTER with 42, then ENTER on empty
        press(11, 1, 1, "t5_clear");
        press(4, 2, 1, "t5_d4");
        press(2, 2, 1, "t5_d2");
        press(12, 3, 2, "t5_enter");
        total++;
        assert (value[7:0] === 8'h42) else begin
            bad++;
            $error("FAIL t5_value: got %h want 42", value[7:0]);
        end
        press(12, 2, 1, "t5_enter_empty");

        // 6: ignored codes and CLEAR on empty, then CLEAR after 3 digits
        press(13, 2, 1, "t6_k13");
        press(14, 2, 1, "t6_k14");
        press(15, 2, 1, "t6_k15");
        press(11, 2, 1, "t6_clear_empty");
        press(5, 1, 1, "t6_d5");
        press(6, 1, 1, "t6_d6");
        press(8, 1, 1, "t6_d8");
        press(11, 2, 1, "t6_clear");

        // Random key sequences, with occasional resets during a held key
        for (int n = 0; n < 400; n++) begin
            int r, k;
            r = int'($urandom_range(0, 19));
            if (r < 13) k = r % 10;
            else        k = 10 + (r - 13) % 6;
            if ($urandom_range(0, 49) == 0)
                do_reset(1'($urandom_range(0, 1)), "rand_reset");
            press(k, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
